control_unit: RTL and testbench
===============================

// Module: control_unit
// PURPOSE
//  Controller FSM of the 16-bit lab processor. Owns PC and IR, fetches from
//  the 128x16 instruction ROM, and drives control strobes into the datapath
//  (data RAM, register file, ALU). Sits directly upstream of the datapath.
//  Also exports IR, PC and state code to the top level for HEX display.
// PARAMETERS
//  PC_W    7   instruction-memory address width (128 words)
//  DATA_AW 8   data-memory address width, taken from IR[11:4]
// PORTS
//  clock       in   1   system clock
//  reset       in   1   asynchronous reset, active-low
//  IM_data     in   16  instruction ROM read data, valid the cycle after IM_rd
//  PC_out      out  7   instruction ROM address; also shown on HEX
//  IM_rd       out  1   instruction ROM read enable
//  IR_out      out  16  instruction register, for HEX0-HEX3
//  D_addr      out  8   data RAM address
//  D_wr        out  1   data RAM write enable
//  RF_s        out  1   RF write mux: 1 = data RAM, 0 = ALU
//  RF_W_addr   out  4   RF write address
//  RF_W_en     out  1   RF write enable
//  RF_Ra_addr  out  4   RF port A read address
//  RF_Rb_addr  out  4   RF port B read address
//  ALU_s0      out  3   ALU function: 000 pass-A, 001 add, 010 sub
//  state_out   out  4   current state code, for HEX display
//  step        in   1   single-step pulse; present only with SINGLE_STEP_EN
// BEHAVIOUR
//  Reset (async, reset==0): state=INIT, PC=0, IR=0. All strobes 0,
//   all addresses 0, ALU_s0=000.
//  ISA by IR[15:12]: 0 NOOP, 1 STORE D[IR[11:4]]<=RF[IR[3:0]],
//   2 LOAD RF[IR[3:0]]<=D[IR[11:4]], 3 ADD RF[IR[3:0]]<=RF[IR[11:8]]+RF[IR[7:4]],
//   4 SUB (same fields, minus), 5 HALT. Opcodes 6-15 execute as NOOP.
//  States and transitions; all outputs are Moore, decoded from state and IR:
//   INIT   -> FETCH, no strobes.
//   FETCH  IM_rd=1 at PC_out=PC. PC<=PC+1 on exit, wrapping 127->0 silently.
//          -> DECODE.
//   DECODE IR<=IM_data. Next state decoded from IM_data[15:12], not the old IR.
//   NOOP   -> FETCH.
//   LOAD_A D_addr=IR[11:4], RF_W_addr=IR[3:0], RF_s=1, RF_W_en=0 -> LOAD_B.
//   LOAD_B same addresses, RF_s=1, RF_W_en=1 -> FETCH.
//   STORE  D_addr=IR[11:4], RF_Ra_addr=IR[3:0], D_wr=1 for exactly 1 cycle
//          -> FETCH.
//   ADD    Ra=IR[11:8], Rb=IR[7:4], W=IR[3:0], ALU_s0=001, RF_s=0,
//          RF_W_en=1 -> FETCH.
//   SUB    as ADD with ALU_s0=010 -> FETCH.
//   HALT   all strobes 0. PC and IR frozen. Leaves only via reset.
//  Latency: NOOP/STORE/ADD/SUB 3 cycles, LOAD 4 cycles, from FETCH to next FETCH.
//  No strobe is asserted outside the states listed above.
//  Reset asserted mid-instruction aborts it at once. No partial write after
//   reset deassertion.
//  State codes: INIT 0, FETCH 1, DECODE 2, NOOP 3, LOAD_A 4, LOAD_B 5,
//   STORE 6, ADD 7, SUB 8, HALT 9.
// CONFIGURATION
//  SINGLE_STEP_EN defined: port step exists. INIT and the final execute state
//   of each instruction hold until step==1 is sampled, then go to FETCH.
//   step is already synchronised and one clock wide.
//  SINGLE_STEP_EN undefined: no step port. Free-running as described above.
// STRUCTURE
//  processor_pkg holds: opcode constants, state encodings, ALU select codes,
//   and field positions (OP_MSB, DADDR_MSB/LSB, etc.).
//  One sub-module: program_counter. It is a PC_W-bit register with clear and
//   increment, wrapping at 2**PC_W.
//  Remaining FSM and output decode live in control_unit.
// TESTING
//  1. Reset low mid-run -> next edge-independent: state_out=0, PC_out=0,
//     all strobes 0. Release -> FETCH on next clock.
//  2. ROM[0]=16'h3124 (ADD R4=R1+R2) -> after DECODE, one ADD cycle with
//     Ra=1, Rb=2, W=4, ALU_s0=001, RF_W_en=1. FETCH of PC=1 three cycles
//     after the first FETCH.
//  3. ROM[0]=16'h2053 (LOAD R3<=D[5]) -> LOAD_A: D_addr=5, RF_W_en=0.
//     LOAD_B: RF_s=1, RF_W_en=1, W=3. Total 4 cycles.
//  4. ROM[0]=16'h10A7 (STORE D[10]<=R7) -> D_wr high exactly 1 cycle with
//     D_addr=10 and Ra=7.
//  5. ROM[127]=NOOP, ROM[0]=HALT, PC preset to 127 via program run ->
//     PC wraps to 0, HALT entered, state_out=9 held 20+ cycles, PC stable.
//  6. SINGLE_STEP_EN: with step=0, FSM waits in INIT. Each step pulse
//     retires exactly one instruction.

Source files
------------

// File: rtl/processor_pkg.sv
// Shared constants for the 16-bit lab processor: opcodes, state codes,
// ALU selects, instruction field positions and the control-strobe bundle.
package processor_pkg;

    localparam int OP_MSB    = 15;
    localparam int OP_LSB    = 12;
    localparam int DADDR_MSB = 11;
    localparam int DADDR_LSB = 4;
    localparam int RA_MSB    = 11;
    localparam int RA_LSB    = 8;
    localparam int RB_MSB    = 7;
    localparam int RB_LSB    = 4;
    localparam int RW_MSB    = 3;
    localparam int RW_LSB    = 0;

    localparam logic [3:0] OP_NOOP  = 4'd0;
    localparam logic [3:0] OP_STORE = 4'd1;
    localparam logic [3:0] OP_LOAD  = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_HALT  = 4'd5;

    localparam logic [3:0] S_INIT   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_NOOP   = 4'd3;
    localparam logic [3:0] S_LOAD_A = 4'd4;
    localparam logic [3:0] S_LOAD_B = 4'd5;
    localparam logic [3:0] S_STORE  = 4'd6;
    localparam logic [3:0] S_ADD    = 4'd7;
    localparam logic [3:0] S_SUB    = 4'd8;
    localparam logic [3:0] S_HALT   = 4'd9;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;

    typedef struct packed {
        logic [7:0] d_addr;
        logic       d_wr;
        logic       rf_s;
        logic [3:0] rf_w_addr;
        logic       rf_w_en;
        logic [3:0] rf_ra_addr;
        logic [3:0] rf_rb_addr;
        logic [2:0] alu_s0;
    } ctrl_t;

    // First execute state for an opcode; unknown opcodes retire as NOOP.
    function automatic logic [3:0] decode_op(input logic [3:0] op);
        case (op)
            OP_STORE: decode_op = S_STORE;
            OP_LOAD:  decode_op = S_LOAD_A;
            OP_ADD:   decode_op = S_ADD;
            OP_SUB:   decode_op = S_SUB;
            OP_HALT:  decode_op = S_HALT;
            default:  decode_op = S_NOOP;
        endcase
    endfunction

endpackage

// File: rtl/program_counter.sv
// PC_W-bit program counter with synchronous clear and increment,
// wrapping silently at 2**PC_W.
module program_counter #(
    parameter int PC_W = 7
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            clr,
    input  logic            inc,
    output logic [PC_W-1:0] pc
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            pc <= '0;
        else if (clr)
            pc <= '0;
        else if (inc)
            pc <= pc + 1'b1;
    end

endmodule

// File: rtl/control_unit.sv
// Controller FSM of the 16-bit lab processor: fetch/decode/execute with Moore
// strobes into the datapath. Optional SINGLE_STEP_EN adds a step input.
module control_unit
    import processor_pkg::*;
#(
    parameter int PC_W    = 7,
    parameter int DATA_AW = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [15:0]        IM_data,
    output logic [PC_W-1:0]    PC_out,
    output logic               IM_rd,
    output logic [15:0]        IR_out,
    output logic [DATA_AW-1:0] D_addr,
    output logic               D_wr,
    output logic               RF_s,
    output logic [3:0]         RF_W_addr,
    output logic               RF_W_en,
    output logic [3:0]         RF_Ra_addr,
    output logic [3:0]         RF_Rb_addr,
    output logic [2:0]         ALU_s0,
    output logic [3:0]         state_out
`ifdef SINGLE_STEP_EN
    ,
    input  logic               step
`endif
);

    logic [3:0]  state, state_next;
    logic [15:0] ir;
    logic [PC_W-1:0] pc;
    logic        go;
    logic        fresh;
    ctrl_t       ctrl;

`ifdef SINGLE_STEP_EN
    assign go = step;

    // A held execute state fires its write strobe only on its first cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            fresh <= 1'b1;
        else
            fresh <= (state_next != state);
    end
`else
    assign go    = 1'b1;
    assign fresh = 1'b1;
`endif

    program_counter #(.PC_W(PC_W)) u_pc (
        .clock (clock),
        .reset (reset),
        .clr   (state == S_INIT),
        .inc   (state == S_FETCH),
        .pc    (pc)
    );

    always_comb begin
        state_next = state;
        case (state)
            S_INIT:   if (go) state_next = S_FETCH;
            S_FETCH:  state_next = S_DECODE;
            // ROM data arrives this cycle; IR still holds the previous word.
            S_DECODE: state_next = decode_op(IM_data[OP_MSB:OP_LSB]);
            S_LOAD_A: state_next = S_LOAD_B;
            S_NOOP, S_LOAD_B, S_STORE, S_ADD, S_SUB:
                      if (go) state_next = S_FETCH;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_INIT;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_INIT;
            ir    <= '0;
        end else begin
            state <= state_next;
            if (state == S_DECODE)
                ir <= IM_data;
        end
    end

    always_comb begin
        ctrl = '0;
        case (state)
            S_LOAD_A: begin
                ctrl.d_addr    = ir[DADDR_MSB:DADDR_LSB];
                ctrl.rf_w_addr = ir[RW_MSB:RW_LSB];
                ctrl.rf_s      = 1'b1;
            end
            S_LOAD_B: begin
                ctrl.d_addr    = ir[DADDR_MSB:DADDR_LSB];
                ctrl.rf_w_addr = ir[RW_MSB:RW_LSB];
                ctrl.rf_s      = 1'b1;
                ctrl.rf_w_en   = fresh;
            end
            S_STORE: begin
                ctrl.d_addr     = ir[DADDR_MSB:DADDR_LSB];
                ctrl.rf_ra_addr = ir[RW_MSB:RW_LSB];
                ctrl.d_wr       = fresh;
            end
            S_ADD, S_SUB: begin
                ctrl.rf_ra_addr = ir[RA_MSB:RA_LSB];
                ctrl.rf_rb_addr = ir[RB_MSB:RB_LSB];
                ctrl.rf_w_addr  = ir[RW_MSB:RW_LSB];
                ctrl.alu_s0     = (state == S_ADD) ? ALU_ADD : ALU_SUB;
                ctrl.rf_w_en    = fresh;
            end
            default: ;
        endcase
    end

    assign PC_out     = pc;
    assign IM_rd      = (state == S_FETCH);
    assign IR_out     = ir;
    assign D_addr     = ctrl.d_addr;
    assign D_wr       = ctrl.d_wr;
    assign RF_s       = ctrl.rf_s;
    assign RF_W_addr  = ctrl.rf_w_addr;
    assign RF_W_en    = ctrl.rf_w_en;
    assign RF_Ra_addr = ctrl.rf_ra_addr;
    assign RF_Rb_addr = ctrl.rf_rb_addr;
    assign ALU_s0     = ctrl.alu_s0;
    assign state_out  = state;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit (default build, free-running FSM) with a
// registered 128x16 ROM model feeding IM_data.
module tb_control_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] IM_data = '0;
    logic [6:0]  PC_out;
    logic        IM_rd;
    logic [15:0] IR_out;
    logic [7:0]  D_addr;
    logic        D_wr, RF_s, RF_W_en;
    logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, state_out;
    logic [2:0]  ALU_s0;

    logic [15:0] rom [128];
    int pass_cnt = 0;
    int total_cnt = 0;

    control_unit dut (
        .clock      (clock),
        .reset      (reset),
        .IM_data    (IM_data),
        .PC_out     (PC_out),
        .IM_rd      (IM_rd),
        .IR_out     (IR_out),
        .D_addr     (D_addr),
        .D_wr       (D_wr),
        .RF_s       (RF_s),
        .RF_W_addr  (RF_W_addr),
        .RF_W_en    (RF_W_en),
        .RF_Ra_addr (RF_Ra_addr),
        .RF_Rb_addr (RF_Rb_addr),
        .ALU_s0     (ALU_s0),
        .state_out  (state_out)
    );

    always #5 clock = ~clock;

    always @(posedge clock)
        if (IM_rd) IM_data <= rom[PC_out];

    function automatic logic any_strobe();
        return D_wr | RF_W_en | IM_rd | RF_s | (ALU_s0 != 3'd0) | (D_addr != 8'd0)
             | (RF_W_addr != 4'd0) | (RF_Ra_addr != 4'd0) | (RF_Rb_addr != 4'd0);
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    endtask

    // Reset, release between edges, return 1ns after the edge that enters FETCH.
    task automatic boot();
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        clear_rom();
        rom[0] = 16'h3124;
        boot();
        tick(); tick();
        total_cnt++; if (RF_W_en !== 1'b1) $display("FAIL rst_pre_add_wen got %b want 1", RF_W_en); else pass_cnt++;
        reset = 1'b0; #1;
        total_cnt++; if (state_out !== 4'd0) $display("FAIL rst_state got %0d want 0", state_out); else pass_cnt++;
        total_cnt++; if (PC_out !== 7'd0) $display("FAIL rst_pc got %0d want 0", PC_out); else pass_cnt++;
        total_cnt++; if (IR_out !== 16'h0000) $display("FAIL rst_ir got %h want 0000", IR_out); else pass_cnt++;
        total_cnt++; if (any_strobe() !== 1'b0) $display("FAIL rst_strobes got %b want 0", any_strobe()); else pass_cnt++;
        tick(); tick();
        total_cnt++; if (state_out !== 4'd0) $display("FAIL rst_hold got %0d want 0", state_out); else pass_cnt++;
        @(negedge clock); reset = 1'b1;
        tick();
        total_cnt++; if (state_out !== 4'd1) $display("FAIL rst_release got %0d want 1", state_out); else pass_cnt++;
        total_cnt++; if (IM_rd !== 1'b1 || PC_out !== 7'd0) $display("FAIL rst_fetch0 got rd=%b pc=%0d want rd=1 pc=0", IM_rd, PC_out); else pass_cnt++;
    endtask

    task automatic test_add();
        clear_rom();
        rom[0] = 16'h3124;
        boot();
        total_cnt++; if (state_out !== 4'd1) $display("FAIL add_fetch got %0d want 1", state_out); else pass_cnt++;
        tick();
        total_cnt++; if (state_out !== 4'd2 || any_strobe() !== 1'b0) $display("FAIL add_decode got st=%0d strb=%b want st=2 strb=0", state_out, any_strobe()); else pass_cnt++;
        tick();
        total_cnt++; if (state_out !== 4'd7) $display("FAIL add_state got %0d want 7", state_out); else pass_cnt++;
        total_cnt++; if ({RF_Ra_addr, RF_Rb_addr, RF_W_addr} !== 12'h124) $display("FAIL add_regs got %h want 124", {RF_Ra_addr, RF_Rb_addr, RF_W_addr}); else pass_cnt++;
        total_cnt++; if (ALU_s0 !== 3'b001 || RF_W_en !== 1'b1 || RF_s !== 1'b0) $display("FAIL add_ctl got alu=%b wen=%b s=%b want 001 1 0", ALU_s0, RF_W_en, RF_s); else pass_cnt++;
        total_cnt++; if (IR_out !== 16'h3124) $display("FAIL add_ir got %h want 3124", IR_out); else pass_cnt++;
        tick();
        total_cnt++; if (state_out !== 4'd1 || PC_out !== 7'd1) $display("FAIL add_next_fetch got st=%0d pc=%0d want 1 1", state_out, PC_out); else pass_cnt++;
    endtask

    task automatic test_load();
        clear_rom();
        rom[0] = 16'h2053;
        boot(); tick(); tick();
        total_cnt++; if (state_out !== 4'd4) $display("FAIL load_a_state got %0d want 4", state_out); else pass_cnt++;
        total_cnt++; if (D_addr !== 8'd5 || RF_W_en !== 1'b0 || RF_s !== 1'b1) $display("FAIL load_a_ctl got a=%0d wen=%b s=%b want 5 0 1", D_addr, RF_W_en, RF_s); else pass_cnt++;
        tick();
        total_cnt++; if (state_out !== 4'd5) $display("FAIL load_b_state got %0d want 5", state_out); else pass_cnt++;
        total_cnt++; if (RF_s !== 1'b1 || RF_W_en !== 1'b1 || RF_W_addr !== 4'd3 || D_addr !== 8'd5) $display("FAIL load_b_ctl got s=%b wen=%b w=%0d a=%0d want 1 1 3 5", RF_s, RF_W_en, RF_W_addr, D_addr); else pass_cnt++;
        tick();
        total_cnt++; if (state_out !== 4'd1 || PC_out !== 7'd1) $display("FAIL load_latency got st=%0d pc=%0d want 1 1", state_out, PC_out); else pass_cnt++;
    endtask

    task automatic test_store();
        int hits = 0;
        logic ok_fields = 1'b1;
        clear_rom();
        rom[0] = 16'h10A7;
        boot();
        for (int i = 0; i < 10; i++) begin
            if (D_wr) begin
                hits++;
                if (D_addr !== 8'd10 || RF_Ra_addr !== 4'd7 || state_out !== 4'd6) ok_fields = 1'b0;
            end
            tick();
        end
        total_cnt++; if (hits != 1) $display("FAIL store_dwr_cycles got %0d want 1", hits); else pass_cnt++;
        total_cnt++; if (ok_fields !== 1'b1) $display("FAIL store_fields got %b want 1", ok_fields); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp [17] = '{4'd1, 4'd2, 4'd7, 4'd1, 4'd2, 4'd8, 4'd1, 4'd2, 4'd4,
                                 4'd5, 4'd1, 4'd2, 4'd3, 4'd1, 4'd2, 4'd9, 4'd9};
        clear_rom();
        rom[0] = 16'h3124; rom[1] = 16'h4567; rom[2] = 16'h2053;
        rom[3] = 16'hF000; rom[4] = 16'h5000;
        boot();
        for (int i = 0; i < 17; i++) begin
            total_cnt++; if (state_out !== exp[i]) $display("FAIL b2b_state[%0d] got %0d want %0d", i, state_out, exp[i]); else pass_cnt++;
            if (i == 5) begin
                total_cnt++;
                if (ALU_s0 !== 3'b010 || {RF_Ra_addr, RF_Rb_addr, RF_W_addr} !== 12'h567 || RF_W_en !== 1'b1)
                    $display("FAIL sub_ctl got alu=%b regs=%h wen=%b want 010 567 1", ALU_s0, {RF_Ra_addr, RF_Rb_addr, RF_W_addr}, RF_W_en);
                else pass_cnt++;
            end
            if (i == 12) begin
                total_cnt++; if (any_strobe() !== 1'b0) $display("FAIL op15_noop_strobes got %b want 0", any_strobe()); else pass_cnt++;
            end
            tick();
        end
    endtask

    task automatic test_wrap_halt();
        logic found = 1'b0;
        int bad = 0;
        clear_rom();
        boot(); tick();
        rom[0] = 16'h5000;
        for (int i = 0; i < 600 && !found; i++) begin
            if (state_out == 4'd1 && PC_out == 7'd127) found = 1'b1;
            else tick();
        end
        total_cnt++; if (found !== 1'b1) $display("FAIL wrap_reach127 got %b want 1", found); else pass_cnt++;
        tick();
        total_cnt++; if (PC_out !== 7'd0) $display("FAIL wrap_pc got %0d want 0", PC_out); else pass_cnt++;
        tick(); tick(); tick(); tick();
        total_cnt++; if (state_out !== 4'd9 || PC_out !== 7'd1) $display("FAIL halt_enter got st=%0d pc=%0d want 9 1", state_out, PC_out); else pass_cnt++;
        total_cnt++; if (IR_out !== 16'h5000) $display("FAIL halt_ir got %h want 5000", IR_out); else pass_cnt++;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (state_out !== 4'd9 || PC_out !== 7'd1 || IR_out !== 16'h5000 || any_strobe() !== 1'b0) bad++;
        end
        total_cnt++; if (bad != 0) $display("FAIL halt_hold bad_cycles got %0d want 0", bad); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_load();
        test_store();
        test_back_to_back();
        test_wrap_halt();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
